// File: rtl/ray_scan_sequencer_pkg.sv
// Shared vector types for the ray scan path.
//   fp_t                : Q8.24 fixed-point coordinate
//   COORD_STEP_DEFAULT  : default per-pixel coordinate increment (1/8 in Q8.24)
//   scan_state_e        : scan sequencer states
package ray_scan_sequencer_pkg;

    typedef logic [31:0] fp_t;

    localparam fp_t COORD_STEP_DEFAULT = 32'h0020_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

endpackage

// File: rtl/inflight_credit_counter.sv
// Outstanding-coordinate credit counter.
//   clk, rst_n    : clock, async active-low reset
//   issue         : a coordinate was transferred this cycle
//   retire        : the ray unit returned a result this cycle
//   count         : registered outstanding count
//   count_next_c  : combinational next value of count
//   credit_err    : sticky, set by a retire with nothing outstanding and no issue
module inflight_credit_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic             retire,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next_c,
    output logic             credit_err
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             credit_err_q;
    logic             credit_err_d;

    // Issue and retire in the same cycle cancel, even at zero outstanding.
    always_comb begin
        count_d      = count_q;
        credit_err_d = credit_err_q;
        if (issue && !retire) begin
            count_d = count_q + CNT_W'(1);
        end else if (!issue && retire) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                credit_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            credit_err_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign count        = count_q;
    assign count_next_c = count_d;
    assign credit_err   = credit_err_q;

endmodule

// File: rtl/ray_scan_sequencer.sv
// Raster scan coordinate generator feeding a ray unit with credit-limited issue.
//   out_stream_aclk, periph_resetn : clock, async active-low reset
//   enable                         : render frames continuously while high
//   coord_valid/coord_ready        : coordinate handshake (screen_x, screen_y, sof, eol)
//   result_valid                   : one pulse per shaded pixel returned
//   inflight                       : outstanding coordinates
//   frame_done/frame_count         : frame completion pulse and wrapping count
//   credit_err                     : sticky unexpected-result flag
module ray_scan_sequencer
    import ray_scan_sequencer_pkg::*;
#(
    parameter int unsigned H_PIXELS     = 640,
    parameter int unsigned V_PIXELS     = 480,
    parameter fp_t         COORD_STEP   = COORD_STEP_DEFAULT,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                              out_stream_aclk,
    input  logic                              periph_resetn,
    input  logic                              enable,
    output logic                              coord_valid,
    input  logic                              coord_ready,
    output fp_t                               screen_x,
    output fp_t                               screen_y,
    output logic                              coord_sof,
    output logic                              coord_eol,
    input  logic                              result_valid,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              frame_done,
    output logic [15:0]                       frame_count,
    output logic                              credit_err
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int unsigned ROW_W = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_PIXELS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_PIXELS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);

    scan_state_e      state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    fp_t              x_q, x_d;
    fp_t              y_q, y_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic             done_q, done_d;
    logic [15:0]      frames_q, frames_d;
    logic             xfer_c;
    logic [CNT_W-1:0] inflight_cnt;
    logic [CNT_W-1:0] inflight_next_c;

    assign xfer_c = valid_q && coord_ready;

    inflight_credit_counter #(
        .CNT_W (CNT_W)
    ) u_credit (
        .clk          (out_stream_aclk),
        .rst_n        (periph_resetn),
        .issue        (xfer_c),
        .retire       (result_valid),
        .count        (inflight_cnt),
        .count_next_c (inflight_next_c),
        .credit_err   (credit_err)
    );

    // Scan state, raster position and next-cycle handshake outputs.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        x_d      = x_q;
        y_d      = y_q;
        done_d   = 1'b0;
        frames_d = frames_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_RUN: begin
                if (xfer_c) begin
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        x_d   = '0;
                        if (row_q == LAST_ROW) begin
                            state_d = ST_DRAIN;
                            row_d   = '0;
                            y_d     = '0;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                            y_d   = y_q + COORD_STEP;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                        x_d   = x_q + COORD_STEP;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight_cnt == '0) begin
                    done_d   = 1'b1;
                    frames_d = frames_q + 16'd1;
                    state_d  = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Valid only drops after a transfer fills the credit window, never spontaneously.
        valid_d = (state_d == ST_RUN) && (inflight_next_c < MAX_CNT);
        sof_d   = (col_d == '0) && (row_d == '0);
        eol_d   = (col_d == LAST_COL);
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            done_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            x_q      <= x_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
            done_q   <= done_d;
            frames_q <= frames_d;
        end
    end

    assign coord_valid = valid_q;
    assign screen_x    = x_q;
    assign screen_y    = y_q;
    assign coord_sof   = sof_q;
    assign coord_eol   = eol_q;
    assign inflight    = inflight_cnt;
    assign frame_done  = done_q;
    assign frame_count = frames_q;

endmodule

// File: tb/tb_ray_scan_sequencer.sv
// Randomized bench for ray_scan_sequencer against a pixel-index reference model.
module tb_ray_scan_sequencer;
    import ray_scan_sequencer_pkg::*;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 6;
    localparam int unsigned MAXI = 4;
    localparam int unsigned CW   = $clog2(MAXI + 1);
    localparam fp_t         STEP = 32'h3000_0000;   // large step so coordinates wrap
    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          coord_ready = 1'b0;
    logic          result_valid = 1'b0;
    logic          coord_valid;
    fp_t           screen_x;
    fp_t           screen_y;
    logic          coord_sof;
    logic          coord_eol;
    logic [CW-1:0] inflight;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          credit_err;

    ray_scan_sequencer #(
        .H_PIXELS     (H),
        .V_PIXELS     (V),
        .COORD_STEP   (STEP),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .out_stream_aclk (clk),
        .periph_resetn   (rst_n),
        .enable          (enable),
        .coord_valid     (coord_valid),
        .coord_ready     (coord_ready),
        .screen_x        (screen_x),
        .screen_y        (screen_y),
        .coord_sof       (coord_sof),
        .coord_eol       (coord_eol),
        .result_valid    (result_valid),
        .inflight        (inflight),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .credit_err      (credit_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame progress as a linear pixel index.
    int   m_phase;
    int   m_pix;
    int   m_infl;
    int   m_frames;
    bit   m_err;
    bit   m_done;
    int   cyc;
    int   ret_q[$];
    int   last_ret;
    bit   ret_en;
    bit   man_rv;
    int   rdy_pct;
    int unsigned lat_lo, lat_hi;
    int   dut_xfers;
    bit   prev_stall;
    fp_t  prev_x, prev_y;
    logic prev_sof, prev_eol;

    function automatic fp_t exp_x(input int pix);
        logic [31:0] c;
        c = 32'(pix % int'(H));
        return c * STEP;
    endfunction

    function automatic fp_t exp_y(input int pix);
        logic [31:0] r;
        r = 32'(pix / int'(H));
        return r * STEP;
    endfunction

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_pix    = 0;
        m_infl   = 0;
        m_frames = 0;
        m_err    = 1'b0;
        m_done   = 1'b0;
        ret_q.delete();
        last_ret   = -1;
        prev_stall = 1'b0;
    endtask

    // Asynchronous reset: outputs must be cleared without a clock edge.
    task automatic do_reset();
        rst_n        = 1'b0;
        enable       = 1'b0;
        coord_ready  = 1'b0;
        result_valid = 1'b0;
        man_rv       = 1'b0;
        #1;
        check("rst_valid", 32'(coord_valid), 32'd0);
        check("rst_x", screen_x, 32'd0);
        check("rst_y", screen_y, 32'd0);
        check("rst_sof", 32'(coord_sof), 32'd0);
        check("rst_eol", 32'(coord_eol), 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_credit_err", 32'(credit_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive inputs, predict, clock, compare.
    task automatic cycle();
        bit xfer, exp_valid, rv_sched;
        int infl_old, tmp, t;
        coord_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < 32'(rdy_pct));
        rv_sched = 1'b0;
        if (ret_q.size() > 0) begin
            if (ret_q[0] == cyc) begin
                rv_sched = 1'b1;
                tmp = ret_q.pop_front();
            end
        end
        result_valid = man_rv | rv_sched;
        #1;
        prev_stall = coord_valid && !coord_ready;
        prev_x     = screen_x;
        prev_y     = screen_y;
        prev_sof   = coord_sof;
        prev_eol   = coord_eol;
        if (coord_valid && coord_ready) dut_xfers++;

        exp_valid = (m_phase == PH_RUN) && (m_infl < int'(MAXI));
        xfer      = exp_valid && coord_ready;
        infl_old  = m_infl;
        m_done    = 1'b0;
        if (xfer && !result_valid) m_infl++;
        else if (!xfer && result_valid) begin
            if (m_infl > 0) m_infl--;
            else m_err = 1'b1;
        end
        case (m_phase)
            PH_IDLE: if (enable) begin m_phase = PH_RUN; m_pix = 0; end
            PH_RUN: if (xfer) begin
                m_pix++;
                if (m_pix == int'(H * V)) begin m_pix = 0; m_phase = PH_DRAIN; end
            end
            default: if (infl_old == 0) begin
                m_done = 1'b1;
                m_frames++;
                m_phase = enable ? PH_RUN : PH_IDLE;
            end
        endcase
        if (xfer && ret_en) begin
            t = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (t <= last_ret) t = last_ret + 1;
            ret_q.push_back(t);
            last_ret = t;
        end

        @(posedge clk);
        #1;
        cyc++;
        exp_valid = (m_phase == PH_RUN) && (m_infl < int'(MAXI));
        check("valid", 32'(coord_valid), 32'(exp_valid));
        check("inflight", 32'(inflight), 32'(m_infl));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("frame_count", 32'(frame_count), 32'(m_frames & 16'hFFFF));
        check("credit_err", 32'(credit_err), 32'(m_err));
        if (exp_valid) begin
            check("screen_x", screen_x, exp_x(m_pix));
            check("screen_y", screen_y, exp_y(m_pix));
            check("sof", 32'(coord_sof), 32'(m_pix == 0));
            check("eol", 32'(coord_eol), 32'((m_pix % int'(H)) == int'(H) - 1));
        end
        if (prev_stall) begin
            check("stall_valid", 32'(coord_valid), 32'd1);
            check("stall_x", screen_x, prev_x);
            check("stall_y", screen_y, prev_y);
            check("stall_sof", 32'(coord_sof), 32'(prev_sof));
            check("stall_eol", 32'(coord_eol), 32'(prev_eol));
        end
    endtask

    initial begin
        int f0;
        cyc = 0; ret_en = 1'b0; man_rv = 1'b0; rdy_pct = 100;
        lat_lo = 3; lat_hi = 3; dut_xfers = 0;
        model_reset();
        do_reset();

        // Stray result while idle: sticky error, count stays at zero.
        man_rv = 1'b1;
        cycle();
        man_rv = 1'b0;
        check("credit_err_set", 32'(credit_err), 32'd1);
        check("credit_err_infl", 32'(inflight), 32'd0);
        cycle();
        do_reset();

        // Full-throughput frame, results returned 3 cycles after each transfer.
        ret_en = 1'b1; rdy_pct = 100; lat_lo = 3; lat_hi = 3; enable = 1'b1;
        cycle();
        check("first_valid", 32'(coord_valid), 32'd1);
        check("first_sof", 32'(coord_sof), 32'd1);
        check("first_x", screen_x, 32'd0);
        dut_xfers = 0;
        for (int i = 0; i < 2000 && m_frames < 1; i++) cycle();
        check("frame1_reached", 32'(frame_count), 32'd1);
        check("frame1_xfers", 32'(dut_xfers), 32'(H * V));

        // No results returned: exactly MAXI transfers, then the next coordinate is held.
        do_reset();
        ret_en = 1'b0; enable = 1'b1; dut_xfers = 0;
        for (int i = 0; i < 15; i++) cycle();
        check("noret_xfers", 32'(dut_xfers), 32'(MAXI));
        check("noret_valid", 32'(coord_valid), 32'd0);
        check("noret_infl", 32'(inflight), 32'(MAXI));
        check("noret_held_x", screen_x, 32'(MAXI) * STEP);

        // Transfer and result in the same cycle at two outstanding.
        do_reset();
        ret_en = 1'b0; enable = 1'b1;
        for (int i = 0; i < 20 && m_infl < 2; i++) cycle();
        check("pre_infl2", 32'(inflight), 32'd2);
        man_rv = 1'b1;
        cycle();
        man_rv = 1'b0;
        check("same_cycle_infl", 32'(inflight), 32'd2);

        // Random backpressure and latencies over multiple frames.
        do_reset();
        ret_en = 1'b1; rdy_pct = 50; lat_lo = 1; lat_hi = 6; enable = 1'b1;
        for (int i = 0; i < 5000 && m_frames < 2; i++) cycle();
        check("rand_frames", 32'(frame_count), 32'd2);

        // Drop enable mid-frame: frame completes and the sequencer idles.
        for (int i = 0; i < 2000 && !(m_phase == PH_RUN && m_pix >= 20); i++) cycle();
        f0 = m_frames;
        enable = 1'b0;
        for (int i = 0; i < 3000 && m_phase != PH_IDLE; i++) cycle();
        check("drop_frame_count", 32'(frame_count), 32'(f0 + 1));
        for (int i = 0; i < 10; i++) cycle();
        check("drop_idle_valid", 32'(coord_valid), 32'd0);

        // Reset mid-frame, then restart from pixel 0.
        enable = 1'b1;
        for (int i = 0; i < 2000 && m_pix < 10; i++) cycle();
        do_reset();
        ret_en = 1'b1; rdy_pct = 70; enable = 1'b1;
        for (int i = 0; i < 3000 && m_frames < 1; i++) cycle();
        check("restart_frames", 32'(frame_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
